// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the memory stage: load/store size encodings and
// the data-memory handshake state type.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends
// it according to the load's funct3.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        case (addr)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unsupported funct3 encodings return zero rather than a partial word.
    always_comb begin
        result = 32'h0;
        case (funct3)
            F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    result = {{16{half_lane[15]}}, half_lane};
            F3_W:    result = rdata;
            F3_BU:   result = {24'h0, byte_lane};
            F3_HU:   result = {16'h0, half_lane};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline M stage: drives the data-memory request/handshake, stalls the front
// of the pipe while memory is busy, and holds the M/W pipeline register.
module memory_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        M_valid,
    input  logic        M_mem_read,
    input  logic        M_mem_write,
    input  logic        M_reg_write,
    input  logic [2:0]  M_funct3,
    input  logic [1:0]  M_rd_src_sel,
    input  logic [4:0]  M_rd_addr,
    input  logic [31:0] M_alu_result,
    input  logic [31:0] M_write_data,
    input  logic [31:0] M_pc_auipc_target,
    input  logic [31:0] M_pc_plus_4,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] W_alu_result,
    output logic [31:0] W_load_ext,
    output logic [31:0] W_pc_auipc_target,
    output logic [31:0] W_pc_plus_4,
    output logic [1:0]  W_rd_src_sel,
    output logic [4:0]  W_rd_addr,
    output logic        W_reg_write,
    output logic        M_stall,
    output logic        M_misaligned
);

    mem_state_t  state;
    mem_state_t  state_next;
    logic        mem_access;
    logic        misaligned_addr;
    logic        misaligned_access;
    logic [31:0] load_result;

    assign mem_access        = M_valid & (M_mem_read | M_mem_write);
    assign misaligned_addr   = ((M_funct3[1:0] == 2'b01) & M_alu_result[0]) |
                               ((M_funct3[1:0] == 2'b10) & (M_alu_result[1:0] != 2'b00));
    assign misaligned_access = mem_access & misaligned_addr;

    // Gating with rst_n keeps the request and stall low while reset is held,
    // even if the upstream stage still presents a memory op.
    assign dmem_req     = rst_n & mem_access & ~misaligned_access;
    assign M_stall      = dmem_req & ~dmem_ready;
    assign M_misaligned = rst_n & misaligned_access;
    assign dmem_we      = M_mem_write;
    assign dmem_addr    = {M_alu_result[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = M_write_data;
        if (M_mem_read) begin
            dmem_be = 4'b1111;
        end else begin
            case (M_funct3)
                F3_B: begin
                    dmem_be    = 4'b0001 << M_alu_result[1:0];
                    dmem_wdata = {4{M_write_data[7:0]}};
                end
                F3_H: begin
                    dmem_be    = M_alu_result[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{M_write_data[15:0]}};
                end
                F3_W:    dmem_be = 4'b1111;
                default: dmem_be = 4'b0000;
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .addr   (M_alu_result[1:0]),
        .funct3 (M_funct3),
        .result (load_result)
    );

    always_comb begin
        state_next = state;
        case (state)
            MEM_IDLE: if (dmem_req && !dmem_ready) state_next = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MEM_IDLE;
        else        state <= state_next;
    end

    // While stalled only a bubble enters W; the other fields keep their values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_alu_result      <= 32'h0;
            W_load_ext        <= 32'h0;
            W_pc_auipc_target <= 32'h0;
            W_pc_plus_4       <= 32'h0;
            W_rd_src_sel      <= 2'b00;
            W_rd_addr         <= 5'd0;
            W_reg_write       <= 1'b0;
        end else if (M_stall) begin
            W_reg_write <= 1'b0;
        end else begin
            W_alu_result      <= M_alu_result;
            W_load_ext        <= (M_valid && M_mem_read && !misaligned_access) ? load_result : 32'h0;
            W_pc_auipc_target <= M_pc_auipc_target;
            W_pc_plus_4       <= M_pc_plus_4;
            W_rd_src_sel      <= M_rd_src_sel;
            W_rd_addr         <= M_rd_addr;
            W_reg_write       <= M_valid & M_reg_write & ~misaligned_access;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by random
// load/store/ALU traffic against a behavioural model of the stage.
module tb_memory_stage;

    logic        clk;
    logic        rst_n;
    logic        M_valid;
    logic        M_mem_read;
    logic        M_mem_write;
    logic        M_reg_write;
    logic [2:0]  M_funct3;
    logic [1:0]  M_rd_src_sel;
    logic [4:0]  M_rd_addr;
    logic [31:0] M_alu_result;
    logic [31:0] M_write_data;
    logic [31:0] M_pc_auipc_target;
    logic [31:0] M_pc_plus_4;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] W_alu_result;
    logic [31:0] W_load_ext;
    logic [31:0] W_pc_auipc_target;
    logic [31:0] W_pc_plus_4;
    logic [1:0]  W_rd_src_sel;
    logic [4:0]  W_rd_addr;
    logic        W_reg_write;
    logic        M_stall;
    logic        M_misaligned;

    int checkCount;
    int failCount;

    memory_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .M_valid           (M_valid),
        .M_mem_read        (M_mem_read),
        .M_mem_write       (M_mem_write),
        .M_reg_write       (M_reg_write),
        .M_funct3          (M_funct3),
        .M_rd_src_sel      (M_rd_src_sel),
        .M_rd_addr         (M_rd_addr),
        .M_alu_result      (M_alu_result),
        .M_write_data      (M_write_data),
        .M_pc_auipc_target (M_pc_auipc_target),
        .M_pc_plus_4       (M_pc_plus_4),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_be           (dmem_be),
        .dmem_wdata        (dmem_wdata),
        .dmem_ready        (dmem_ready),
        .dmem_rdata        (dmem_rdata),
        .W_alu_result      (W_alu_result),
        .W_load_ext        (W_load_ext),
        .W_pc_auipc_target (W_pc_auipc_target),
        .W_pc_plus_4       (W_pc_plus_4),
        .W_rd_src_sel      (W_rd_src_sel),
        .W_rd_addr         (W_rd_addr),
        .W_reg_write       (W_reg_write),
        .M_stall           (M_stall),
        .M_misaligned      (M_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Access width in bytes implied by funct3; unknown encodings carry no alignment rule.
    function automatic int accessBytes(input logic [2:0] f3);
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        if (f3 == 3'b010) return 4;
        return 1;
    endfunction

    function automatic logic modelMisaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % accessBytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [2:0] f3);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> (8 * (addr % 4));
        b = shifted[7:0];
        h = shifted[15:0];
        case (f3)
            3'b000:  return (b >= 8'h80)    ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
            3'b001:  return (h >= 16'h8000) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
            3'b010:  return word;
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] modelStoreBe(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'b000:  return 4'(1 << (addr % 4));
            3'b001:  return 4'(3 << (addr % 4));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] modelStoreData(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            3'b000:  return (data % 256) * 32'h0101_0101;
            3'b001:  return (data % 65536) * 32'h0001_0001;
            default: return data;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one instruction from posedge+1, answers with memory after 'latency'
    // wait cycles, and checks the handshake every cycle and W after completion.
    task automatic applyStimulus(input logic valid, input logic rd, input logic wr, input logic regw,
                                 input logic [2:0] f3, input logic [1:0] srcSel, input logic [4:0] rdAddr,
                                 input logic [31:0] alu, input logic [31:0] wdata,
                                 input logic [31:0] auipc, input logic [31:0] pc4,
                                 input int latency, input logic [31:0] rdata);
        logic isMem, mis, expReq;
        isMem  = valid && (rd || wr);
        mis    = isMem && modelMisaligned(f3, alu);
        expReq = isMem && !mis;
        M_valid = valid; M_mem_read = rd; M_mem_write = wr; M_reg_write = regw;
        M_funct3 = f3; M_rd_src_sel = srcSel; M_rd_addr = rdAddr;
        M_alu_result = alu; M_write_data = wdata; M_pc_auipc_target = auipc; M_pc_plus_4 = pc4;
        dmem_rdata = rdata;
        for (int cyc = 0; cyc <= latency; cyc++) begin
            dmem_ready = (cyc == latency);
            @(negedge clk);
            checkOutput("dmem_req", 32'(dmem_req), 32'(expReq));
            checkOutput("M_stall", 32'(M_stall), 32'(expReq && cyc < latency));
            checkOutput("M_misaligned", 32'(M_misaligned), 32'(mis));
            if (cyc > 0) checkOutput("W_reg_write_bubble", 32'(W_reg_write), 32'h0);
            if (expReq) begin
                checkOutput("dmem_addr", dmem_addr, alu - (alu % 4));
                checkOutput("dmem_we", 32'(dmem_we), 32'(wr));
                checkOutput("dmem_be", 32'(dmem_be), 32'(rd ? 4'hF : modelStoreBe(f3, alu)));
                if (wr) checkOutput("dmem_wdata", dmem_wdata, modelStoreData(f3, wdata));
            end
            @(posedge clk);
            #1;
        end
        dmem_ready = 1'b0;
        checkOutput("W_reg_write", 32'(W_reg_write), 32'(valid && regw && !mis));
        checkOutput("W_load_ext", W_load_ext, (valid && rd && !mis) ? modelLoad(rdata, alu, f3) : 32'h0);
        checkOutput("W_alu_result", W_alu_result, alu);
        checkOutput("W_pc_auipc_target", W_pc_auipc_target, auipc);
        checkOutput("W_pc_plus_4", W_pc_plus_4, pc4);
        checkOutput("W_rd_addr", 32'(W_rd_addr), 32'(rdAddr));
        checkOutput("W_rd_src_sel", 32'(W_rd_src_sel), 32'(srcSel));
    endtask

    initial begin
        logic [2:0] loadF3 [6];
        logic [2:0] storeF3 [3];
        int kind;
        logic [2:0] f3;
        logic [31:0] addr;
        checkCount = 0;
        failCount  = 0;
        loadF3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        storeF3 = '{3'b000, 3'b001, 3'b010};
        rst_n = 1'b0;
        M_valid = 0; M_mem_read = 0; M_mem_write = 0; M_reg_write = 0;
        M_funct3 = 0; M_rd_src_sel = 0; M_rd_addr = 0; M_alu_result = 0; M_write_data = 0;
        M_pc_auipc_target = 0; M_pc_plus_4 = 0; dmem_ready = 0; dmem_rdata = 0;

        // Reset state, with a memory op pending at the inputs
        M_valid = 1; M_mem_read = 1; M_funct3 = 3'b010; M_alu_result = 32'h100;
        @(negedge clk);
        checkOutput("reset_dmem_req", 32'(dmem_req), 32'h0);
        checkOutput("reset_M_stall", 32'(M_stall), 32'h0);
        checkOutput("reset_W_reg_write", 32'(W_reg_write), 32'h0);
        checkOutput("reset_W_alu_result", W_alu_result, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LW zero-wait
        applyStimulus(1, 1, 0, 1, 3'b010, 2'b01, 5'd3, 32'h100, 32'h0, 32'h11, 32'h22, 0, 32'hDEADBEEF);
        // LB with three wait cycles, sign-extended top byte
        applyStimulus(1, 1, 0, 1, 3'b000, 2'b01, 5'd4, 32'h103, 32'h0, 32'h33, 32'h44, 3, 32'h80FF_0000);
        // SH upper half
        applyStimulus(1, 0, 1, 0, 3'b001, 2'b00, 5'd0, 32'h202, 32'h0000_ABCD, 32'h55, 32'h66, 1, 32'h0);
        // Misaligned LW
        applyStimulus(1, 1, 0, 1, 3'b010, 2'b01, 5'd5, 32'h101, 32'h0, 32'h77, 32'h88, 0, 32'h1234_5678);
        // Non-memory AUIPC-style op
        applyStimulus(1, 0, 0, 1, 3'b000, 2'b10, 5'd6, 32'h9, 32'h0, 32'h4000, 32'h104, 0, 32'h0);

        // Reset asserted while waiting on memory
        M_valid = 1; M_mem_read = 1; M_mem_write = 0; M_reg_write = 1; M_funct3 = 3'b010;
        M_alu_result = 32'h300; dmem_ready = 0;
        @(negedge clk);
        checkOutput("wait_dmem_req", 32'(dmem_req), 32'h1);
        checkOutput("wait_M_stall", 32'(M_stall), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wait_dmem_req", 32'(dmem_req), 32'h0);
        checkOutput("rst_wait_M_stall", 32'(M_stall), 32'h0);
        checkOutput("rst_wait_W_pc_auipc", W_pc_auipc_target, 32'h0);
        checkOutput("rst_wait_W_pc_plus_4", W_pc_plus_4, 32'h0);
        M_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_W_reg_write", 32'(W_reg_write), 32'h0);
        applyStimulus(1, 1, 0, 1, 3'b100, 2'b01, 5'd7, 32'h105, 32'h0, 32'h1, 32'h2, 0, 32'hCAFE_F00D);
        // Invalid slot must not request or write back
        applyStimulus(0, 1, 0, 1, 3'b010, 2'b01, 5'd8, 32'h400, 32'h0, 32'h3, 32'h4, 0, 32'h5);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            addr = $urandom & 32'h0000_0FFF;
            case (kind)
                0: begin
                    f3 = loadF3[$urandom_range(0, 5)];
                    applyStimulus(1, 1, 0, 1, f3, 2'b01, 5'($urandom), addr, $urandom,
                                  $urandom, $urandom, $urandom_range(0, 3), $urandom);
                end
                1: begin
                    f3 = storeF3[$urandom_range(0, 2)];
                    applyStimulus(1, 0, 1, 0, f3, 2'b00, 5'($urandom), addr, $urandom,
                                  $urandom, $urandom, $urandom_range(0, 3), $urandom);
                end
                2: applyStimulus(1, 0, 0, 1, 3'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom,
                                 $urandom, $urandom, 0, $urandom);
                default: applyStimulus(0, 1'($urandom), 0, 1, 3'b010, 2'b01, 5'($urandom), addr, $urandom,
                                       $urandom, $urandom, 0, $urandom);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
